// File: rtl/flt_add_if.sv
// Handshake and byte-wide data-memory port between the float-add engine and its environment.
interface flt_add_if;
  logic       start;
  logic       ack;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  // Environment side: issues start, owns the memory.
  modport master (
    output start,
    output mem_rdata,
    input  ack,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata
  );

  // Engine side: responds to start, drives the memory port.
  modport slave (
    input  start,
    input  mem_rdata,
    output ack,
    output mem_addr,
    output mem_wr_en,
    output mem_wdata
  );
endinterface

// File: rtl/flt_add_engine.sv
// Half-precision (binary16) truncating adder. It fetches two operands byte-wise
// from data memory, adds them, and writes the result back before raising ack.
module flt_add_engine #(
  parameter logic [7:0] OP1_ADDR = 8'd8,
  parameter logic [7:0] OP2_ADDR = 8'd10,
  parameter logic [7:0] RES_ADDR = 8'd12
) (
  input  logic     clk,
  input  logic     reset,
  flt_add_if.slave bus
);

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned MANT_W = 11;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_ALIGN, S_ADD, S_NORM, S_WRL, S_WRH, S_DONE
  } state_t;

  state_t state;
  logic   ack_q;

  logic [15:0] op1;
  logic [15:0] op2;
  logic [15:0] result;

  logic              al_sign;
  logic              al_sub;
  logic [EXP_W-1:0]  al_exp;
  logic [MANT_W-1:0] al_big;
  logic [MANT_W-1:0] al_small;

  // One spare exponent bit so a carry out of exponent 31 is still seen as overflow.
  logic              nm_sign;
  logic [EXP_W:0]    nm_exp;
  logic [MANT_W:0]   nm_mant;

  logic              swap;
  logic [15:0]       big;
  logic [15:0]       sml;
  logic [EXP_W-1:0]  shamt;
  logic [MANT_W-1:0] big_m;
  logic [MANT_W-1:0] sml_m;
  logic [MANT_W-1:0] sml_al;

  // Order operands by magnitude (ties keep op1) and align the smaller mantissa.
  always_comb begin
    swap   = op2[14:0] > op1[14:0];
    big    = swap ? op2 : op1;
    sml    = swap ? op1 : op2;
    big_m  = (big[14:10] == 5'd0) ? '0 : {1'b1, big[9:0]};
    sml_m  = (sml[14:10] == 5'd0) ? '0 : {1'b1, sml[9:0]};
    shamt  = big[14:10] - sml[14:10];
    sml_al = (shamt >= 5'd11) ? '0 : (sml_m >> shamt);
  end

  logic [EXP_W:0]  exp_inc;
  logic [EXP_W:0]  exp_dec;
  logic [MANT_W:0] mant_shl;
  logic            norm_done;
  logic [15:0]     norm_res;
  logic [MANT_W:0] norm_mant;
  logic [EXP_W:0]  norm_exp;

  // Single normalization step: carry, zero, one left shift, flush or already normal.
  always_comb begin
    exp_inc   = nm_exp + 6'd1;
    exp_dec   = nm_exp - 6'd1;
    mant_shl  = {nm_mant[MANT_W-1:0], 1'b0};
    norm_done = 1'b0;
    norm_res  = '0;
    norm_mant = nm_mant;
    norm_exp  = nm_exp;
    if (nm_mant[MANT_W]) begin
      norm_done = 1'b1;
      if (exp_inc >= 6'd31) norm_res = {nm_sign, 5'h1F, 10'h000};
      else                  norm_res = {nm_sign, exp_inc[4:0], nm_mant[10:1]};
    end else if (nm_mant == '0) begin
      norm_done = 1'b1;
      norm_res  = 16'h0000;
    end else if (!nm_mant[MANT_W-1]) begin
      if (nm_exp <= 6'd1) begin
        norm_done = 1'b1;
        norm_res  = {nm_sign, 15'h0000};
      end else begin
        norm_mant = mant_shl;
        norm_exp  = exp_dec;
        norm_done = mant_shl[MANT_W-1];
        norm_res  = {nm_sign, exp_dec[4:0], mant_shl[9:0]};
      end
    end else begin
      norm_done = 1'b1;
      norm_res  = {nm_sign, nm_exp[4:0], nm_mant[9:0]};
    end
  end

  // Control FSM plus the operand/datapath registers it sequences.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ack_q    <= 1'b0;
      op1      <= '0;
      op2      <= '0;
      result   <= '0;
      al_sign  <= 1'b0;
      al_sub   <= 1'b0;
      al_exp   <= '0;
      al_big   <= '0;
      al_small <= '0;
      nm_sign  <= 1'b0;
      nm_exp   <= '0;
      nm_mant  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state <= S_RD0;
            ack_q <= 1'b0;
          end
        end
        S_RD0: begin
          op1[7:0] <= bus.mem_rdata;
          state    <= S_RD1;
        end
        S_RD1: begin
          op1[15:8] <= bus.mem_rdata;
          state     <= S_RD2;
        end
        S_RD2: begin
          op2[7:0] <= bus.mem_rdata;
          state    <= S_RD3;
        end
        S_RD3: begin
          op2[15:8] <= bus.mem_rdata;
          state     <= S_ALIGN;
        end
        S_ALIGN: begin
          al_sign  <= big[15];
          al_sub   <= big[15] ^ sml[15];
          al_exp   <= big[14:10];
          al_big   <= big_m;
          al_small <= sml_al;
          state    <= S_ADD;
        end
        S_ADD: begin
          nm_sign <= al_sign;
          nm_exp  <= {1'b0, al_exp};
          nm_mant <= al_sub ? ({1'b0, al_big} - {1'b0, al_small})
                            : ({1'b0, al_big} + {1'b0, al_small});
          state   <= S_NORM;
        end
        S_NORM: begin
          nm_mant <= norm_mant;
          nm_exp  <= norm_exp;
          result  <= norm_res;
          if (norm_done) state <= S_WRL;
        end
        S_WRL: state <= S_WRH;
        S_WRH: begin
          state <= S_DONE;
          ack_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack = ack_q;

  // Memory port decoded from the current state; idle value is all zero.
  always_comb begin
    bus.mem_addr  = 8'd0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = 8'd0;
    case (state)
      S_RD0: bus.mem_addr = OP1_ADDR;
      S_RD1: bus.mem_addr = 8'(OP1_ADDR + 8'd1);
      S_RD2: bus.mem_addr = OP2_ADDR;
      S_RD3: bus.mem_addr = 8'(OP2_ADDR + 8'd1);
      S_WRL: begin
        bus.mem_addr  = RES_ADDR;
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = result[7:0];
      end
      S_WRH: begin
        bus.mem_addr  = 8'(RES_ADDR + 8'd1);
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = result[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flt_add_engine.sv
// Self-checking bench for flt_add_engine: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_flt_add_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flt_add_if bus();

  flt_add_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Byte memory with combinational read; bench preloads go through the same process.
  logic [7:0]  mem [256];
  int          wr_count = 0;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [15:0] pre_data = 16'd0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (pre_en) begin
      mem[pre_addr]            <= pre_data[7:0];
      mem[8'(pre_addr + 8'd1)] <= pre_data[15:8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load16(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  // Reference: apply the add rules on plain integers; n is the number of NORM cycles.
  function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output int n);
    logic [15:0] bg, sm;
    longint mb, ms, r;
    int eb, es, d, e, shifts;
    if (b[14:0] > a[14:0]) begin bg = b; sm = a; end
    else begin bg = a; sm = b; end
    eb = int'(bg[14:10]);
    es = int'(sm[14:10]);
    mb = (eb == 0) ? 0 : 1024 + longint'(bg[9:0]);
    ms = (es == 0) ? 0 : 1024 + longint'(sm[9:0]);
    d  = eb - es;
    ms = (d >= 11) ? 0 : ms / (longint'(1) << d);
    r  = (bg[15] == sm[15]) ? mb + ms : mb - ms;
    e  = eb;
    n  = 1;
    if (r == 0) begin
      res = 16'h0000;
    end else if (r >= 2048) begin
      r = r / 2;
      e = e + 1;
      res = (e >= 31) ? {bg[15], 5'h1F, 10'h000} : {bg[15], 5'(e), 10'(r)};
    end else begin
      shifts = 0;
      while (r < 1024 && e > 1) begin
        r = r * 2;
        e = e - 1;
        shifts++;
      end
      if (r < 1024) begin
        res = {bg[15], 15'h0000};
        n   = shifts + 1;
      end else begin
        res = {bg[15], 5'(e), 10'(r)};
        n   = (shifts == 0) ? 1 : shifts;
      end
    end
  endfunction

  // One full operation: preload operands, pulse start, time ack, read back the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int exp_lat, input bit busy_pulse);
    int cyc;
    bit got;
    load16(8'd8, a);
    load16(8'd10, b);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "/ack_drop"}, 32'(bus.ack), 32'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      bus.start = (busy_pulse && cyc == 2) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ack) got = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/result"}, 32'({mem[13], mem[12]}), 32'(exp_res));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "/ack_hold"}, 32'(bus.ack), 32'd1);
  endtask

  logic [15:0] ra, rb, rr;
  int          rn, base_wr;

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ack", 32'(bus.ack), 32'd0);
    check("rst/wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst/addr", 32'(bus.mem_addr), 32'd0);
    check("rst/wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("equal", 16'h1A04, 16'h1A04, 16'h1E04, 9, 1'b0);
    check("equal/op1_kept", 32'({mem[9], mem[8]}), 32'h1A04);
    check("equal/op2_kept", 32'({mem[11], mem[10]}), 32'h1A04);
    run_op("aligned", 16'h4A10, 16'h4204, 16'h4B91, 9, 1'b0);
    run_op("gap", 16'h5000, 16'h1A04, 16'h5000, 9, 1'b0);
    run_op("zero_op", 16'h0000, 16'h4204, 16'h4204, 9, 1'b0);
    run_op("unlike", 16'h4A10, 16'hC204, 16'h488F, 9, 1'b0);
    run_op("cancel", 16'h4204, 16'hC204, 16'h0000, 9, 1'b0);
    run_op("shift10", 16'h3C00, 16'hBBFF, 16'h1400, 18, 1'b0);
    run_op("ovf_pos", 16'h7BFF, 16'h7BFF, 16'h7C00, 9, 1'b0);
    run_op("ovf_neg", 16'hFBFF, 16'hFBFF, 16'hFC00, 9, 1'b0);
    run_op("busy_start", 16'h4A10, 16'h4204, 16'h4B91, 9, 1'b1);

    // Reset during ALIGN must abandon the operation without touching the result bytes.
    load16(8'd12, 16'hAAAA);
    load16(8'd8, 16'h4A10);
    load16(8'd10, 16'h4204);
    base_wr = wr_count;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst/ack", 32'(bus.ack), 32'd0);
    check("midrst/wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst/res_lo", 32'(mem[12]), 32'hAA);
    check("midrst/res_hi", 32'(mem[13]), 32'hAA);
    check("midrst/no_write", 32'(wr_count), 32'(base_wr));
    check("midrst/ack_idle", 32'(bus.ack), 32'd0);
    run_op("after_rst", 16'h4A10, 16'h4204, 16'h4B91, 9, 1'b0);

    run_op("b2b_equal", 16'h1A04, 16'h1A04, 16'h1E04, 9, 1'b0);
    run_op("b2b_aligned", 16'h4A10, 16'h4204, 16'h4B91, 9, 1'b0);

    // Randomized operands: mix of unrelated, nearby-exponent and near-cancelling pairs.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rb = 16'($urandom);
        1: rb = {1'($urandom), ra[14:10] ^ 5'($urandom_range(0, 3)), 10'($urandom)};
        default: rb = {~ra[15], ra[14:10], ra[9:0] ^ 10'($urandom_range(0, 15))};
      endcase
      ref_add(ra, rb, rr, rn);
      run_op($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, rr, 8 + rn, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
